paddle_ctrl: RTL and testbench

Multi-channel paddle position controller for the Pong game. It holds up to NUM_PADDLES paddle Y positions and updates them once per frame tick. Each paddle runs in manual mode (up/down buttons) or auto mode (tracks the ball Y). Movement accelerates, saturates at the play-field boundaries and never wraps. Outputs feed the renderer and collision logic in the top module.

---
 rtl/paddle_ctrl.sv | 152 +++++++++++++++
 tb/tb_paddle_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: multi-channel Pong paddle position controller.
// Each paddle accelerates under button or ball-tracking control and clamps at the field edges.
module paddle_ctrl #(
  parameter int NUM_PADDLES     = 2,
  parameter int YW              = 10,
  parameter int TOP_BOUNDARY    = 0,
  parameter int BOTTOM_BOUNDARY = 480,
  parameter int PAD_H           = 64,
  parameter int DY_MIN          = 2,
  parameter int DY_MAX          = 8,
  parameter int ACCEL           = 1,
  parameter int DEADBAND        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic [NUM_PADDLES-1:0]    btn_up,
  input  logic [NUM_PADDLES-1:0]    btn_dn,
  input  logic [NUM_PADDLES-1:0]    auto_mode,
  input  logic [YW-1:0]             ball_y,
  output logic [NUM_PADDLES*YW-1:0] pad_y,
  output logic [NUM_PADDLES-1:0]    at_top,
  output logic [NUM_PADDLES-1:0]    at_bottom,
  output logic [NUM_PADDLES-1:0]    moving
);

  localparam int W1 = YW + 1;
  localparam int XW = YW + 2;

  localparam logic [YW-1:0] TOP_Y   = YW'(TOP_BOUNDARY);
  localparam logic [YW-1:0] BOT_Y   = YW'(BOTTOM_BOUNDARY - PAD_H);
  localparam logic [YW-1:0] CTR_Y   =
    YW'((TOP_BOUNDARY + BOTTOM_BOUNDARY - PAD_H) / 2);
  localparam logic [YW-1:0] SPD_MIN = YW'(DY_MIN);
  localparam logic [YW-1:0] SPD_MAX = YW'(DY_MAX);
  localparam logic [YW-1:0] SPD_INC = YW'(ACCEL);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN
  } state_e;

  logic [NUM_PADDLES-1:0] up_s1_q, up_s2_q;
  logic [NUM_PADDLES-1:0] dn_s1_q, dn_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      up_s1_q <= '0;
      up_s2_q <= '0;
      dn_s1_q <= '0;
      dn_s2_q <= '0;
    end else begin
      up_s1_q <= btn_up;
      up_s2_q <= up_s1_q;
      dn_s1_q <= btn_dn;
      dn_s2_q <= dn_s1_q;
    end
  end

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_ch
    state_e        st_q, st_d;
    logic [YW-1:0] pos_q, pos_d;
    logic [YW-1:0] spd_q, spd_d;
    logic [YW-1:0] step, spd_inc;
    logic          top_q, top_d;
    logic          bot_q, bot_d;
    logic          mov_q, mov_d;
    logic          man_up, man_dn;
    logic          auto_up, auto_dn;
    logic          req_up, req_dn;
    logic [W1-1:0] up_sum, dn_sum;
    logic [XW-1:0] ctr, ball_x;

    assign man_up  = up_s2_q[g] & ~dn_s2_q[g];
    assign man_dn  = dn_s2_q[g] & ~up_s2_q[g];

    // Deadband is applied on the ball side so nothing can underflow.
    assign ctr     = XW'(pos_q) + XW'(PAD_H / 2);
    assign ball_x  = XW'(ball_y);
    assign auto_up = (ball_x + XW'(DEADBAND)) < ctr;
    assign auto_dn = ball_x > (ctr + XW'(DEADBAND));

    assign req_up  = auto_mode[g] ? auto_up : man_up;
    assign req_dn  = auto_mode[g] ? auto_dn : man_dn;
    assign spd_inc = spd_q + SPD_INC;

    always_comb begin
      st_d   = st_q;
      pos_d  = pos_q;
      spd_d  = spd_q;
      top_d  = top_q;
      bot_d  = bot_q;
      mov_d  = mov_q;
      step   = SPD_MIN;
      up_sum = '0;
      dn_sum = '0;
      if (frame_tick) begin
        if ((!req_up && !req_dn) ||
            (req_up && top_q) ||
            (req_dn && bot_q)) begin
          st_d  = IDLE;
          spd_d = SPD_MIN;
          mov_d = 1'b0;
        end else begin
          if ((req_up && st_q == MOVE_UP) ||
              (req_dn && st_q == MOVE_DOWN)) begin
            step = (spd_inc > SPD_MAX) ? SPD_MAX : spd_inc;
          end
          spd_d  = step;
          up_sum = W1'(pos_q) - W1'(step);
          dn_sum = W1'(pos_q) + W1'(step);
          if (req_up) begin
            st_d  = MOVE_UP;
            pos_d = (up_sum[W1-1] || up_sum < W1'(TOP_Y)) ?
                    TOP_Y : up_sum[YW-1:0];
          end else begin
            st_d  = MOVE_DOWN;
            pos_d = (dn_sum > W1'(BOT_Y)) ? BOT_Y : dn_sum[YW-1:0];
          end
          mov_d = (pos_d != pos_q);
        end
        top_d = (pos_d == TOP_Y);
        bot_d = (pos_d == BOT_Y);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= IDLE;
        pos_q <= CTR_Y;
        spd_q <= SPD_MIN;
        top_q <= (CTR_Y == TOP_Y);
        bot_q <= (CTR_Y == BOT_Y);
        mov_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        pos_q <= pos_d;
        spd_q <= spd_d;
        top_q <= top_d;
        bot_q <= bot_d;
        mov_q <= mov_d;
      end
    end

    assign pad_y[g*YW +: YW] = pos_q;
    assign at_top[g]         = top_q;
    assign at_bottom[g]      = bot_q;
    assign moving[g]         = mov_q;
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed stimulus for paddle_ctrl with a per-cycle
// reference model plus hand-computed position checkpoints.
module tb_paddle_ctrl;
  localparam int N    = 2;
  localparam int YW   = 10;
  localparam int TOP  = 0;
  localparam int MAXY = 416;
  localparam int CTR  = 208;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            frame_tick = 1'b0;
  logic [N-1:0]    btn_up = '0;
  logic [N-1:0]    btn_dn = '0;
  logic [N-1:0]    auto_mode = '0;
  logic [YW-1:0]   ball_y = '0;
  logic [N*YW-1:0] pad_y;
  logic [N-1:0]    at_top, at_bottom, moving;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  paddle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .auto_mode (auto_mode),
    .ball_y    (ball_y),
    .pad_y     (pad_y),
    .at_top    (at_top),
    .at_bottom (at_bottom),
    .moving    (moving)
  );

  // Reference model: position, speed, direction (-1 up, +1 down, 0 idle).
  int m_pos[N];
  int m_spd[N];
  int m_dir[N];
  bit m_mov[N];
  bit h1u[N], h2u[N], h1d[N], h2d[N];
  bit armed = 1'b0;
  int r, s, np, centre, by;

  always @(posedge clk) begin
    if (reset) begin
      armed = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_pos[i] = CTR;
        m_spd[i] = 2;
        m_dir[i] = 0;
        m_mov[i] = 1'b0;
        h1u[i] = 0; h2u[i] = 0; h1d[i] = 0; h2d[i] = 0;
      end
    end else begin
      if (frame_tick) begin
        for (int i = 0; i < N; i++) begin
          if (auto_mode[i]) begin
            centre = m_pos[i] + 32;
            by = int'(ball_y);
            r = (by < centre - 4) ? -1 : ((by > centre + 4) ? 1 : 0);
          end else begin
            r = (h2u[i] && !h2d[i]) ? -1 : ((h2d[i] && !h2u[i]) ? 1 : 0);
          end
          if (r == 0 || (r < 0 && m_pos[i] == TOP) ||
              (r > 0 && m_pos[i] == MAXY)) begin
            m_dir[i] = 0;
            m_spd[i] = 2;
            m_mov[i] = 1'b0;
          end else begin
            s = (r == m_dir[i]) ? ((m_spd[i] + 1 > 8) ? 8 : m_spd[i] + 1) : 2;
            np = m_pos[i] + r * s;
            if (np < TOP) np = TOP;
            if (np > MAXY) np = MAXY;
            m_mov[i] = (np != m_pos[i]);
            m_pos[i] = np;
            m_dir[i] = r;
            m_spd[i] = s;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        h2u[i] = h1u[i]; h1u[i] = btn_up[i];
        h2d[i] = h1d[i]; h1d[i] = btn_dn[i];
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (int'(pad_y[i*YW +: YW]) != m_pos[i] ||
            at_top[i] !== (m_pos[i] == TOP) ||
            at_bottom[i] !== (m_pos[i] == MAXY) ||
            moving[i] !== m_mov[i]) begin
          failures++;
          $display("FAIL model ch%0d t=%0t: pad_y=%0d top=%b bot=%b mov=%b required %0d %b %b %b",
                   i, $time, pad_y[i*YW +: YW], at_top[i], at_bottom[i],
                   moving[i], m_pos[i], (m_pos[i] == TOP),
                   (m_pos[i] == MAXY), m_mov[i]);
        end
      end
    end
  end

  function automatic int pad(int i);
    return int'(pad_y[i*YW +: YW]);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  int exp_dn[10] = '{210, 213, 217, 222, 228, 235, 243, 251, 259, 267};

  initial begin
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    chk("rst pad0", pad(0), 208);
    chk("rst pad1", pad(1), 208);
    chk("rst at_top", int'(at_top), 0);
    chk("rst at_bottom", int'(at_bottom), 0);
    chk("rst moving", int'(moving), 0);

    btn_up = 2'b01;
    cyc(2);
    repeat (5) tick();
    chk("up5 pad0", pad(0), 188);
    chk("up5 moving0", int'(moving[0]), 1);
    do_reset();
    chk("midrst pad0", pad(0), 208);
    chk("midrst moving0", int'(moving[0]), 0);
    cyc(2);
    tick();
    chk("post-rst up pad0", pad(0), 206);
    btn_up = '0;
    cyc(2);
    tick();

    do_reset();
    btn_dn = 2'b10;
    cyc(2);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("accel tick%0d pad1", k), pad(1), exp_dn[k]);
    end
    btn_dn = '0;
    cyc(2);
    tick();

    do_reset();
    btn_up = 2'b01;
    cyc(2);
    repeat (30) tick();
    chk("sat pad0", pad(0), 0);
    chk("sat at_top0", int'(at_top[0]), 1);
    chk("sat moving0", int'(moving[0]), 0);
    btn_up = '0;
    btn_dn = 2'b01;
    cyc(2);
    repeat (60) tick();
    chk("satb pad0", pad(0), 416);
    chk("satb at_bottom0", int'(at_bottom[0]), 1);
    chk("satb at_top0", int'(at_top[0]), 0);
    chk("satb moving0", int'(moving[0]), 0);
    btn_dn = '0;
    cyc(2);
    tick();

    do_reset();
    btn_up = 2'b10;
    btn_dn = 2'b10;
    cyc(2);
    tick();
    chk("conflict pad1", pad(1), 208);
    chk("conflict moving1", int'(moving[1]), 0);
    btn_up = '0;
    cyc(2);
    repeat (3) tick();
    chk("rev down3 pad1", pad(1), 217);
    btn_dn = '0;
    btn_up = 2'b10;
    cyc(2);
    tick();
    chk("rev up1 pad1", pad(1), 215);
    btn_up = '0;
    cyc(2);
    tick();

    do_reset();
    auto_mode = 2'b01;
    ball_y = 10'd243;
    tick();
    chk("auto deadband pad0", pad(0), 208);
    ball_y = 10'd300;
    tick();
    chk("auto dn1 pad0", pad(0), 210);
    tick();
    chk("auto dn2 pad0", pad(0), 213);
    ball_y = 10'd100;
    tick();
    chk("auto rev pad0", pad(0), 211);
    chk("auto manual pad1", pad(1), 208);
    auto_mode = '0;
    tick();

    do_reset();
    btn_up = 2'b10;
    cyc(3);
    btn_up = '0;
    cyc(4);
    chk("gate pad1", pad(1), 208);
    btn_dn = 2'b10;
    cyc(1);
    tick();
    chk("sync1 pad1", pad(1), 208);
    btn_dn = '0;
    cyc(4);
    btn_dn = 2'b10;
    cyc(2);
    tick();
    chk("sync2 pad1", pad(1), 210);
    btn_dn = '0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
